aes_key_expand_seq: RTL

- Sequential AES-128 key expansion unit.
- Generates all 11 round keys from a 128-bit cipher key, one round key per clock.
- Presents the keys on the packed 1408-bit round-key bus that the iterative decryption core consumes.
- Sits directly upstream of that core and replaces its combinational key generator. A start/done handshake tells the core when the schedule is stable.

---
 rtl/aes_key_expand_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key expansion: one round key per clock into a packed schedule bus.
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   start       request expansion of key, accepted only while idle
//   key         128-bit cipher key, w0 = key[127:96]
//   busy        high while the schedule is being generated
//   done        one-cycle pulse after the final round key is written
//   keys_valid  high from done until the next accepted start or reset
//   round_keys  round r in [KW*(NR-r) +: KW]; round 0 at the top, round NR at the bottom
module aes_key_expand_seq #(
    parameter int unsigned NR = 10,
    parameter int unsigned KW = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [KW-1:0]          key,
    output logic                   busy,
    output logic                   done,
    output logic                   keys_valid,
    output logic [KW*(NR+1)-1:0]   round_keys
);

    localparam int unsigned RW = $clog2(NR + 1);
    localparam logic [RW-1:0] LastRound = RW'(NR);

    typedef enum logic {StIdle, StExpand} state_e;

    state_e                 state_q, state_d;
    logic [RW-1:0]          round_q, round_d;
    logic [7:0]             rcon_q, rcon_d;
    logic [KW-1:0]          w_q, w_d;
    logic [KW*(NR+1)-1:0]   rk_q, rk_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   kv_q, kv_d;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse (x^254, which maps 0 to 0) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] inv;
        p   = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [31:0] w0, w1, w2, w3, t;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        w0 = w_q[127:96];
        w1 = w_q[95:64];
        w2 = w_q[63:32];
        w3 = w_q[31:0];
        // SubWord(RotWord(w3)) with the round constant folded into the top byte.
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
           ^ {rcon_q, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        w_d     = w_q;
        rk_d    = rk_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        kv_d    = kv_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    w_d                  = key;
                    rk_d[KW*NR +: KW]    = key;
                    round_d              = RW'(1);
                    rcon_d               = 8'h01;
                    busy_d               = 1'b1;
                    kv_d                 = 1'b0;
                    state_d              = StExpand;
                end
            end
            StExpand: begin
                w_d                                  = {n0, n1, n2, n3};
                rk_d[KW*(NR - 32'(round_q)) +: KW]   = {n0, n1, n2, n3};
                rcon_d                               = xtime(rcon_q);
                round_d                              = round_q + RW'(1);
                if (round_q == LastRound) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    kv_d    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            round_q <= '0;
            rcon_q  <= 8'h01;
            w_q     <= '0;
            rk_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            kv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            w_q     <= w_d;
            rk_q    <= rk_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            kv_q    <= kv_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = kv_q;
    assign round_keys = rk_q;

endmodule
